// File: rtl/csa_pkg.sv
// csa_pkg: shared FSM states, default widths and the bitwise majority helper
package csa_pkg;
  typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;
  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 9;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/csa_vec.sv
// csa_vec: W-bit 3:2 compressor; s=a^b^x, cy=maj<<1, cy_msb=maj bit shifted out
module csa_vec import csa_pkg::*; #(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] x,
  output logic [W-1:0] s,
  output logic [W-1:0] cy,
  output logic         cy_msb
);
  logic [W-1:0] m;
  for (genvar i = 0; i < W; i++) begin : g_maj
    assign m[i] = maj3(a[i], b[i], x[i]);
  end
  assign s      = a ^ b ^ x;
  assign cy     = {m[W-2:0], 1'b0};
  assign cy_msb = m[W-1];
endmodule

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save accumulation of an 8-bit operand stream, resolved to binary per frame
// ports: clk, rst_n (async low); in_valid/in_ready/in_data/in_last operand stream;
//        out_valid/out_ready result handshake with out_sum, out_count (saturating), out_ovf (sticky)
module csa_stream_accumulator import csa_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  state_t           state, state_d;
  logic [ACC_W-1:0] s_q, c_q, x, s_n, c_n;
  logic [CNT_W-1:0] cnt;
  logic             ovf, msb;
  assign in_ready = state == ACC;
  // resolving reuses the compressor with a zero third operand: S^C and (S&C)<<1
  assign x = in_ready ? {{(ACC_W-8){1'b0}}, in_data} : '0;
  csa_vec #(.W(ACC_W)) u_csa (
    .a(s_q), .b(c_q), .x(x), .s(s_n), .cy(c_n), .cy_msb(msb)
  );
  always_comb begin
    state_d = state;
    state_d = (state == ACC && in_valid && in_last) ? RESOLVE :
              (state == RESOLVE && c_q == '0)       ? DONE    :
              (state == DONE && out_ready)          ? ACC     : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      c_q       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: if (in_valid) begin
          s_q <= s_n;
          c_q <= c_n;
          ovf <= ovf | msb;
          cnt <= cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
        end
        RESOLVE: if (c_q == '0) begin
          out_sum   <= s_q;
          out_count <= cnt;
          out_ovf   <= ovf;
          out_valid <= 1'b1;
        end else begin
          s_q <= s_n;
          c_q <= c_n;
          ovf <= ovf | msb;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          s_q       <= '0;
          c_q       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: table-driven and directed checks of the carry-save stream accumulator
module tb_csa_stream_accumulator;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [8:0]  out_count;
  int errors = 0, checks = 0;
  typedef struct {
    logic [7:0] a, b, c;
    int na, nb, nc;
    logic [15:0] es;
    int ec;
    logic eo;
  } vec_t;
  vec_t tbl[8];
  csa_stream_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic put_beat(input logic [7:0] d, input logic last, input int gap);
    bit acc = 0;
    in_valid = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1; in_data = d; in_last = last;
    for (int t = 0; t < 300 && !acc; t++) begin
      acc = in_ready;
      @(negedge clk);
    end
    if (!acc) chk("beat_accept", 0, 1);
    in_valid = 0; in_last = 0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_rise", out_valid, 1);
  endtask
  task automatic take_result(input logic [15:0] es, input int ec, input logic eo,
                             input int lo, input int hi, input bit rnd);
    int lat;
    bit hs = 0;
    wait_valid(lat);
    checks++;
    if (lat < lo || lat > hi) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d..%0d", lat, lo, hi);
    end
    chk("out_sum", out_sum, es);
    chk("out_count", out_count, ec);
    chk("out_ovf", out_ovf, eo);
    chk("in_ready_done", in_ready, 0);
    for (int t = 0; t < 100 && !hs; t++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_ready;
      @(negedge clk);
      if (!hs && out_sum !== es) chk("sum_stable", out_sum, es);
    end
    if (!hs) chk("handshake", 0, 1);
    out_ready = 0;
    chk("valid_clear", out_valid, 0);
  endtask
  task automatic run_vec(input vec_t v);
    int tot = v.na + v.nb + v.nc, idx = 0;
    for (int k = 0; k < v.na; k++) begin put_beat(v.a, idx == tot - 1, 0); idx++; end
    for (int k = 0; k < v.nb; k++) begin put_beat(v.b, idx == tot - 1, 0); idx++; end
    for (int k = 0; k < v.nc; k++) begin put_beat(v.c, idx == tot - 1, 0); idx++; end
    take_result(v.es, v.ec, v.eo, 2, 18, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int lat, rsum, n;
    logic [7:0] d;
    tbl[0] = '{8'hFF, 8'h01, 8'h80, 1, 1, 1, 16'h0180, 3, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 1, 0, 0, 16'h0000, 1, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 8'h00, 258, 0, 0, 16'h00FE, 258, 1'b1};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 257, 0, 0, 16'hFFFF, 257, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 8'h00, 520, 0, 0, 16'h0000, 511, 1'b0};
    tbl[5] = '{8'h01, 8'hFF, 8'h00, 1, 256, 0, 16'hFF01, 257, 1'b0};
    tbl[6] = '{8'h80, 8'h00, 8'h00, 2, 0, 0, 16'h0100, 2, 1'b0};
    tbl[7] = '{8'hFF, 8'h02, 8'h00, 2, 1, 0, 16'h0200, 3, 1'b0};
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    put_beat(8'h00, 1, 0);
    take_result(16'h0000, 1, 0, 2, 2, 0);
    put_beat(8'h11, 0, 1);
    put_beat(8'h22, 1, 0);
    wait_valid(lat);
    in_valid = 1; in_data = 8'h07; in_last = 1;
    for (int t = 0; t < 10; t++) begin
      chk("hold_sum", out_sum, 16'h0033);
      chk("hold_count", out_count, 2);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 0; in_last = 0;
    take_result(16'h0007, 1, 0, 2, 18, 0);
    put_beat(8'h10, 0, 0);
    put_beat(8'h20, 0, 0);
    rst_n = 0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    put_beat(8'h05, 1, 0);
    take_result(16'h0005, 1, 0, 2, 18, 0);
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 40);
      rsum = 0;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom_range(0, 255));
        rsum += d;
        put_beat(d, k == n - 1, $urandom_range(0, 2));
      end
      take_result(rsum[15:0], n, rsum >= 65536, 2, 18, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
